f_add: RTL and testbench

F_ADD -- requirements
Module: f_add

---
 rtl/f_add.sv | 152 +++++++++++++++
 tb/tb_f_add.sv | 132 +++++++++++++
 2 files changed

// File: rtl/f_add.sv
// f_add -- single-precision (IEEE-754 binary32) floating-point adder, one
// registered stage.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset; clears out/out_valid and drops
//              any operation presented on the same edge
//   in_valid   a and b are taken on every rising edge where in_valid=1
//   a, b       binary32 operands
//   out        registered sum, holds its value while no new result arrives
//   out_valid  high for exactly one cycle per accepted operation
//
// Handshake: valid-only, no backpressure. An operation is accepted on every
// rising edge with in_valid=1 and rst=0; its result appears on out with
// out_valid=1 in the following cycle. One operation per cycle sustained.
//
// Configuration macro F_ADD_SUBNORMAL_EN:
//   defined   - subnormal inputs are honoured and tiny results are produced
//               as correctly rounded subnormals
//   undefined - subnormal inputs read as signed zero, tiny results flush to
//               a zero carrying the computed sign
// Rounding is round-to-nearest, ties-to-even.

module f_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        out_valid
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic               sa, sb, sl, eff_sub, swap;
  logic [7:0]         ea, eb, xa, xb, el, es, d, exp_field;
  logic [22:0]        fa, fb;
  logic [23:0]        ma, mb, ml, ms;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [53:0]        wide;
  logic [26:0]        aligned, norm;
  logic [27:0]        sum;
  logic [4:0]         lzc, shamt;
  logic signed [9:0]  e_norm;
  logic               round_up;
  logic [30:0]        rnd;
  logic [31:0]        res;

  always_comb begin
    sa = a[31];  ea = a[30:23];  fa = a[22:0];
    sb = b[31];  eb = b[30:23];  fb = b[22:0];

    a_nan = (ea == 8'hFF) && (fa != 23'd0);
    b_nan = (eb == 8'hFF) && (fb != 23'd0);
    a_inf = (ea == 8'hFF) && (fa == 23'd0);
    b_inf = (eb == 8'hFF) && (fb == 23'd0);

`ifdef F_ADD_SUBNORMAL_EN
    // Subnormals sit at exponent 1 with no hidden bit.
    a_zero = (ea == 8'd0) && (fa == 23'd0);
    b_zero = (eb == 8'd0) && (fb == 23'd0);
    xa     = (ea == 8'd0) ? 8'd1 : ea;
    xb     = (eb == 8'd0) ? 8'd1 : eb;
    ma     = {ea != 8'd0, fa};
    mb     = {eb != 8'd0, fb};
`else
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    xa     = ea;
    xb     = eb;
    ma     = {1'b1, fa};
    mb     = {1'b1, fb};
`endif

    // Magnitude order is the same as the order of the raw bit patterns.
    swap    = b[30:0] > a[30:0];
    sl      = swap ? sb : sa;
    el      = swap ? xb : xa;
    ml      = swap ? mb : ma;
    es      = swap ? xa : xb;
    ms      = swap ? ma : mb;
    eff_sub = sa ^ sb;
    d       = el - es;

    // Align smaller operand: 24 mantissa bits + guard, round, sticky.
    wide = 54'd0;
    if (d >= 8'd27) begin
      aligned = {26'd0, |ms};
    end else begin
      wide    = {ms, 3'b000, 27'd0} >> d;
      aligned = {wide[53:28], |wide[27:0]};
    end

    if (eff_sub) sum = {1'b0, ml, 3'b000} - {1'b0, aligned};
    else         sum = {1'b0, ml, 3'b000} + {1'b0, aligned};

    // Leading zeros of sum[26:0]; highest set bit wins.
    lzc = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lzc = 5'(26 - i);
    end

    e_norm = $signed({2'b00, el});
    shamt  = 5'd0;
    if (sum[27]) begin
      norm   = {sum[27:2], sum[1] | sum[0]};
      e_norm = e_norm + 10'sd1;
    end else begin
`ifdef F_ADD_SUBNORMAL_EN
      // Stop shifting at exponent 1; anything left is a subnormal.
      if ({5'd0, lzc} < ({2'b00, el} - 10'd1)) shamt = lzc;
      else                                     shamt = 5'(el - 8'd1);
`else
      shamt = lzc;
`endif
      norm   = sum[26:0] << shamt;
      e_norm = e_norm - $signed({5'd0, shamt});
    end

    round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    exp_field = norm[26] ? e_norm[7:0] : 8'd0;
    // Rounding carries straight into the exponent field, which also covers
    // subnormal->normal and max-finite->Inf transitions.
    rnd       = {exp_field, norm[25:3]} + {30'd0, round_up};

    if (a_nan || b_nan)                   res = QNAN;
    else if (a_inf && b_inf && (sa != sb)) res = QNAN;
    else if (a_inf)                       res = a;
    else if (b_inf)                       res = b;
    else if (a_zero && b_zero)            res = {sa & sb, 31'd0};
    else if (a_zero)                      res = b;
    else if (b_zero)                      res = a;
    else if (sum == 28'd0)                res = 32'd0;
    else if (e_norm >= 10'sd255)          res = {sl, 8'hFF, 23'd0};
`ifndef F_ADD_SUBNORMAL_EN
    else if (e_norm <= 10'sd0)            res = {sl, 31'd0};
`endif
    else                                  res = {sl, rnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= res;
    end
  end

endmodule

// File: tb/tb_f_add.sv
// Bench for f_add: directed vectors with hand-computed sums, a scoreboard
// queue filled by the driver and drained by a negedge monitor.
module tb_f_add;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] out;
  logic        out_valid;

  // clock / reset
  always #5 clk = ~clk;

  f_add dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .out(out),
    .out_valid(out_valid)
  );

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] hold_exp = 32'd0;
  logic        rst_smp = 1'b1;
  logic [31:0] mon_exp;
  string       mon_name;

  always @(posedge clk) rst_smp <= rst;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // driver tasks
  task automatic issue(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] expv);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; a = ta; b = tb_v;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic reset_with_op(input logic [31:0] ta, input logic [31:0] tb_v);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; a = ta; b = tb_v;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_smp) begin
      check("rst_out", out, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      hold_exp = 32'd0;
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got out_valid=1 out=%h expected no result", out);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, out, mon_exp);
        hold_exp = mon_exp;
      end
    end else begin
      check("hold", out, hold_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);

    issue("add_1p5_2p5",  32'h3FC00000, 32'h40200000, 32'h40800000);
    issue("cancel",       32'hBF800000, 32'h3F800000, 32'h00000000);
    issue("negzero",      32'h80000000, 32'h80000000, 32'h80000000);
    issue("mixzero",      32'h00000000, 32'h80000000, 32'h00000000);
    idle();
    issue("inf_num",      32'h7F800000, 32'h40A00000, 32'h7F800000);
    issue("inf_inf",      32'h7F800000, 32'hFF800000, 32'h7FC00000);
    issue("nan_a",        32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    issue("nan_b",        32'h3F800000, 32'hFF800001, 32'h7FC00000);
    issue("ninf_b",       32'h3F800000, 32'hFF800000, 32'hFF800000);
    idle();
    idle();
    issue("tie_even",     32'h3F800000, 32'h33800000, 32'h3F800000);
    issue("tie_up",       32'h3F800001, 32'h33800000, 32'h3F800002);
    issue("above_half",   32'h3F800000, 32'h33800001, 32'h3F800001);
    issue("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    issue("zero_op",      32'h00000000, 32'hC0A00000, 32'hC0A00000);
    issue("sub_neg",      32'h40400000, 32'hC0A00000, 32'hC0000000);
    issue("half",         32'h3F800000, 32'hBF000000, 32'h3F000000);
    issue("far_shift",    32'h3F800000, 32'h00800000, 32'h3F800000);
`ifdef F_ADD_SUBNORMAL_EN
    issue("subnorm",      32'h00400000, 32'h00400000, 32'h00800000);
    issue("tiny_result",  32'h00800001, 32'h80800000, 32'h00000001);
`else
    issue("subnorm",      32'h00400000, 32'h00400000, 32'h00000000);
    issue("tiny_result",  32'h00800001, 32'h80800000, 32'h00000000);
`endif
    idle();

    // Operation on the reset edge must vanish.
    reset_with_op(32'h3FC00000, 32'h40200000);
    issue("after_reset",  32'h3F800000, 32'h3F800000, 32'h40000000);
    repeat (4) idle();

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
